// File: rtl/deserialize_decrypt.sv
// deserialize_decrypt: receive-side stage behind the MSB-first serializer.
// Reassembles a MSG_SIZE-bit ciphertext word from the serial stream, checks
// start/end framing, and presents the plaintext with sticky valid/error flags.
// Optional feature macro: DESER_DECRYPT_EN. When defined, the word is XORed
// with iKey repeated across the message. When undefined, the word passes
// through unmodified and iKey is ignored.
module deserialize_decrypt #(
    parameter int MSG_SIZE = 512,
    parameter int KEY_SIZE = 64
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iSerial_in,
    input  logic                      iSerial_start,
    input  logic                      iSerial_end,
    input  logic [KEY_SIZE-1:0]       iKey,
    input  logic                      iClear,
    output logic [MSG_SIZE-1:0]       oPlaintext,
    output logic                      oValid,
    output logic                      oError,
    output logic [$clog2(MSG_SIZE):0] oBit_count
);

    localparam int            CW       = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] MSG_LEN  = CW'(MSG_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(MSG_SIZE - 1);

    // LOAD is the single cycle after the last capture; the key is sampled
    // and the plaintext loaded on the edge that leaves it.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [MSG_SIZE-1:0] sr_r, sr_s;
    logic [MSG_SIZE-1:0] plaintext_r, plaintext_s;
    logic                valid_r, valid_s;
    logic                error_r, error_s;
    logic [CW-1:0]       count_r, count_s;
    logic [MSG_SIZE-1:0] decoded_s;

`ifdef DESER_DECRYPT_EN
    // Key repeats every KEY_SIZE bits: bit i uses key bit i % KEY_SIZE.
    function automatic logic [MSG_SIZE-1:0] xor_key(
        input logic [MSG_SIZE-1:0] word,
        input logic [KEY_SIZE-1:0] key
    );
        return word ^ {(MSG_SIZE / KEY_SIZE){key}};
    endfunction

    // Decrypted view of the assembled word.
    always_comb begin
        decoded_s = xor_key(sr_r, iKey);
    end
`else
    logic unused_key_s;
    assign unused_key_s = ^iKey;

    // Pass-through view of the assembled word.
    always_comb begin
        decoded_s = sr_r;
    end
`endif

    // Next-state, capture and flag logic; iClear overrides everything.
    always_comb begin
        state_s     = state_r;
        sr_s        = sr_r;
        plaintext_s = plaintext_r;
        valid_s     = valid_r;
        error_s     = error_r;
        count_s     = count_r;
        if (iClear) begin
            state_s = IDLE;
            sr_s    = '0;
            valid_s = 1'b0;
            error_s = 1'b0;
            count_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iSerial_start) begin
                        sr_s    = {sr_r[MSG_SIZE-2:0], iSerial_in};
                        count_s = (count_r == MSG_LEN) ? count_r : count_r + CW'(1);
                        if (iSerial_end) begin
                            state_s = ERR;
                            error_s = 1'b1;
                            valid_s = 1'b0;
                        end else begin
                            state_s = RECV;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                RECV: begin
                    if (!iSerial_start) begin
                        state_s = ERR;
                        error_s = 1'b1;
                        valid_s = 1'b0;
                    end else begin
                        sr_s    = {sr_r[MSG_SIZE-2:0], iSerial_in};
                        count_s = (count_r == MSG_LEN) ? count_r : count_r + CW'(1);
                        if (count_r == LAST_IDX) begin
                            if (iSerial_end) begin
                                state_s = LOAD;
                            end else begin
                                state_s = ERR;
                                error_s = 1'b1;
                                valid_s = 1'b0;
                            end
                        end else if (iSerial_end) begin
                            state_s = ERR;
                            error_s = 1'b1;
                            valid_s = 1'b0;
                        end else begin
                            state_s = RECV;
                        end
                    end
                end
                LOAD: begin
                    plaintext_s = decoded_s;
                    valid_s     = 1'b1;
                    state_s     = DONE;
                end
                DONE: begin
                    state_s = DONE;
                end
                ERR: begin
                    state_s = ERR;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_r     <= IDLE;
            sr_r        <= '0;
            plaintext_r <= '0;
            valid_r     <= 1'b0;
            error_r     <= 1'b0;
            count_r     <= '0;
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            plaintext_r <= plaintext_s;
            valid_r     <= valid_s;
            error_r     <= error_s;
            count_r     <= count_s;
        end
    end

    assign oPlaintext = plaintext_r;
    assign oValid     = valid_r;
    assign oError     = error_r;
    assign oBit_count = count_r;

endmodule

// File: tb/tb_deserialize_decrypt.sv
// Scoreboard bench for deserialize_decrypt (MSG_SIZE=16, KEY_SIZE=8).
// Stimulus pushes the expected outcome of each frame; a monitor pops and
// compares whenever oValid or oError rises.
module tb_deserialize_decrypt;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iSerial_in = 1'b0;
    logic        iSerial_start = 1'b0;
    logic        iSerial_end = 1'b0;
    logic [7:0]  iKey = 8'hA5;
    logic        iClear = 1'b0;
    logic [15:0] oPlaintext;
    logic        oValid;
    logic        oError;
    logic [4:0]  oBit_count;

`ifdef DESER_DECRYPT_EN
    localparam logic [15:0] PT1 = 16'h99FF;   // 3C5A ^ A5A5
    localparam logic [15:0] PT6 = 16'h0066;   // A5C3 ^ A5A5
`else
    localparam logic [15:0] PT1 = 16'h3C5A;
    localparam logic [15:0] PT6 = 16'hA5C3;
`endif

    typedef struct {
        logic        is_valid;
        logic [15:0] pt;
        logic        chk_cnt;
        logic [4:0]  cnt;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    sb_t e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    deserialize_decrypt #(.MSG_SIZE(16), .KEY_SIZE(8)) dut (
        .iClk(iClk), .iRst(iRst), .iSerial_in(iSerial_in),
        .iSerial_start(iSerial_start), .iSerial_end(iSerial_end),
        .iKey(iKey), .iClear(iClear), .oPlaintext(oPlaintext),
        .oValid(oValid), .oError(oError), .oBit_count(oBit_count)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive nbits of w MSB first, one per negedge; end rises with the last bit.
    task automatic send_bits(input logic [15:0] w, input int nbits, input logic end_on_last);
        for (int i = 0; i < nbits; i++) begin
            @(negedge iClk);
            iSerial_in    = w[15-i];
            iSerial_start = 1'b1;
            iSerial_end   = (end_on_last && (i == nbits - 1)) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic push(input logic v, input logic [15:0] pt, input logic cc,
                        input logic [4:0] cnt, input int c);
        sb_t s;
        s.is_valid = v; s.pt = pt; s.chk_cnt = cc; s.cnt = cnt; s.cyc = c;
        sb.push_back(s);
    endtask

    task automatic idle_clear();
        @(negedge iClk);
        iClear = 1'b1; iSerial_start = 1'b0; iSerial_end = 1'b0;
        @(negedge iClk);
        iClear = 1'b0;
    endtask

    // Monitor: compare against the scoreboard whenever valid or error rises.
    always @(posedge iClk) begin
        #1;
        if ((oValid && !prev_v) || (oError && !prev_e)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, oValid, oError}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("valid_flag", 32'(oValid), 32'(e.is_valid));
                chk("error_flag", 32'(oError), 32'(!e.is_valid));
                chk("plaintext", 32'(oPlaintext), 32'(e.pt));
                if (e.chk_cnt) chk("bit_count", 32'(oBit_count), 32'(e.cnt));
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_v = oValid;
        prev_e = oError;
    end

    initial begin
        // Reset state
        repeat (2) @(negedge iClk);
        chk("rst_plaintext", 32'(oPlaintext), 32'd0);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_error", 32'(oError), 32'd0);
        chk("rst_count", 32'(oBit_count), 32'd0);
        iRst = 1'b1;
        @(negedge iClk);

        // 1: clean frame, valid one clock after the last capture
        send_bits(16'h3C5A, 16, 1'b1);
        push(1'b1, PT1, 1'b1, 5'd16, cyc + 2);
        @(negedge iClk);
        chk("valid_not_on_capture_edge", 32'(oValid), 32'd0);
        repeat (3) @(negedge iClk);
        iSerial_in = ~iSerial_in;
        @(negedge iClk);
        chk("done_hold_valid", 32'(oValid), 32'd1);
        chk("done_hold_count", 32'(oBit_count), 32'd16);
        chk("done_hold_pt", 32'(oPlaintext), 32'(PT1));

        // Clear with stale start/end still high -> IDLE then end-without-frame
        iClear = 1'b1;
        push(1'b0, PT1, 1'b0, 5'd0, cyc + 2);
        @(negedge iClk);
        iClear = 1'b0;
        chk("clear_valid", 32'(oValid), 32'd0);
        chk("clear_count", 32'(oBit_count), 32'd0);
        chk("clear_keeps_pt", 32'(oPlaintext), 32'(PT1));
        @(negedge iClk);
        idle_clear();

        // 2: premature end with bit 10
        send_bits(16'hF0F0, 10, 1'b1);
        push(1'b0, PT1, 1'b1, 5'd10, cyc + 1);
        @(negedge iClk);
        iSerial_start = 1'b0; iSerial_end = 1'b0;
        @(negedge iClk);
        chk("premature_valid", 32'(oValid), 32'd0);
        idle_clear();

        // 3: sixteen bits without end
        send_bits(16'h1234, 16, 1'b0);
        push(1'b0, PT1, 1'b1, 5'd16, cyc + 1);
        @(negedge iClk);
        idle_clear();
        chk("noend_clear_error", 32'(oError), 32'd0);
        chk("noend_clear_count", 32'(oBit_count), 32'd0);

        // 4: start dropped after 5 bits
        send_bits(16'hFFFF, 5, 1'b0);
        @(negedge iClk);
        iSerial_start = 1'b0;
        push(1'b0, PT1, 1'b1, 5'd5, cyc + 1);
        send_bits(16'hFFFF, 3, 1'b0);
        @(negedge iClk);
        chk("dropped_count_frozen", 32'(oBit_count), 32'd5);
        idle_clear();

        // 5: iClear coincides with the last bit
        send_bits(16'hBEEF, 15, 1'b0);
        @(negedge iClk);
        iSerial_in = 1'b1; iSerial_end = 1'b1; iClear = 1'b1;
        @(negedge iClk);
        iClear = 1'b0; iSerial_start = 1'b0; iSerial_end = 1'b0;
        chk("clear_last_valid", 32'(oValid), 32'd0);
        chk("clear_last_count", 32'(oBit_count), 32'd0);
        repeat (2) @(negedge iClk);
        chk("clear_last_valid_later", 32'(oValid), 32'd0);
        chk("clear_last_error_later", 32'(oError), 32'd0);

        // 6: async reset after 7 bits, then a clean frame
        send_bits(16'hFFFF, 7, 1'b0);
        @(posedge iClk);
        #3;
        iRst = 1'b0; iSerial_start = 1'b0;
        #1;
        chk("arst_plaintext", 32'(oPlaintext), 32'd0);
        chk("arst_valid", 32'(oValid), 32'd0);
        chk("arst_error", 32'(oError), 32'd0);
        chk("arst_count", 32'(oBit_count), 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        iKey = 8'hFF;
        send_bits(16'hA5C3, 16, 1'b1);
        push(1'b1, PT6, 1'b1, 5'd16, cyc + 2);
        @(negedge iClk);
        iKey = 8'hA5;
        @(negedge iClk);
        iKey = 8'h00;
        repeat (2) @(negedge iClk);
        chk("key_sampled_once", 32'(oPlaintext), 32'(PT6));
        iSerial_start = 1'b0; iSerial_end = 1'b0;

        repeat (3) @(negedge iClk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserialize_decrypt.md
Name: deserialize_decrypt

Overview:
Receive-side stage that sits directly downstream of the MSB-first serializer. It reassembles the serial ciphertext stream into a MSG_SIZE-bit word, XOR-decrypts it with a repeating key, and presents the plaintext with a sticky valid flag. Framing violations of the start/end protocol are reported on oError. The block is re-armed with iClear.

Parameters:
MSG_SIZE, 512, message width in bits; must be a multiple of KEY_SIZE
KEY_SIZE, 64, key width in bits; the key repeats across the message

Ports:
iClk  input  1  clock
iRst  input  1  reset, asynchronous, active-low
iSerial_in  input  1  serial data bit, MSB of message first
iSerial_start  input  1  level; high while a frame is being sent, and stays high after the last bit
iSerial_end  input  1  level; rises in the same cycle as the last bit, then stays high
iKey  input  KEY_SIZE  decryption key; sampled only in the cycle oValid rises
iClear  input  1  synchronous re-arm pulse
oPlaintext  output  MSG_SIZE  decrypted message
oValid  output  1  sticky high once oPlaintext holds a good frame
oError  output  1  sticky framing error
oBit_count  output  $clog2(MSG_SIZE)+1  number of bits captured so far

Behaviour:
- Reset values (async, iRst=0): state=IDLE, shift register=0, oPlaintext=0, oValid=0, oError=0, oBit_count=0.
- Sampling: a bit is captured on a rising edge when state is IDLE or RECV and iSerial_start=1. Capture shifts left: sr <= {sr[MSG_SIZE-2:0], iSerial_in}, and oBit_count increments.
- IDLE:
  - iSerial_start=1 and iSerial_end=0: capture the first bit, oBit_count=1, go to RECV.
  - iSerial_start=1 and iSerial_end=1: go to ERR (end without a frame).
  - iSerial_end=1 and iSerial_start=0: ignored.
- RECV, per capturing edge, with n = oBit_count before the edge:
  - n+1 < MSG_SIZE and iSerial_end=1: go to ERR (premature end).
  - n+1 == MSG_SIZE and iSerial_end=1: go to DONE.
  - n+1 == MSG_SIZE and iSerial_end=0: go to ERR (missing end).
  - iSerial_start=0 in RECV: go to ERR (dropped frame); no capture.
- DONE: entered on the edge after the last bit is captured.
  - On that edge, load oPlaintext from the complete word: bit i = word[i] ^ iKey[i % KEY_SIZE]. Set oValid=1.
  - Latency: oValid rises one clock after the edge that captures bit 0.
  - Afterwards, oPlaintext and oValid hold; all serial inputs are ignored, including the still-high start/end.
- ERR: oError=1 and held. oValid=0. oPlaintext is unchanged. Serial inputs are ignored.
- iClear=1, any state: next state is IDLE with sr, oBit_count, oValid and oError cleared. oPlaintext keeps its last value. iClear has priority over every capture or transition in that cycle.
  - After iClear, a still-high iSerial_start with iSerial_end=1 (the stale sticky flags from the previous frame) is the IDLE end-without-frame case, so it goes to ERR. The upstream block must be reset or reloaded before re-arming.
- oValid and oError are never high simultaneously.
- Reset mid-frame: all state is lost; the bench must not rely on partial data.
- oBit_count saturates at MSG_SIZE; it never wraps.

Optional Feature:
Macro DESER_DECRYPT_EN.
- Defined: XOR with iKey as described above.
- Undefined: oPlaintext = received word unmodified, iKey is unused, and no XOR logic is synthesised. Timing and protocol are identical.

Test Plan:
1. MSG_SIZE=16, KEY_SIZE=8, key 8'hA5, serial stream of 16'h3C5A MSB first with end on bit 16 -> oValid=1 one clock after the last bit, oPlaintext=16'h99FF (or 16'h3C5A without DESER_DECRYPT_EN), oError=0, oBit_count=16.
2. End asserted with bit 10 of 16 -> oError=1 on that edge, oValid stays 0, oBit_count=10.
3. Sixteen bits sent with no end -> oError=1 at bit 16; the subsequent iClear returns oError=0, oBit_count=0, state IDLE.
4. Start deasserted after 5 bits -> oError=1; later bits do not change oBit_count (remains 5).
5. iClear asserted in the same cycle as the last bit with end=1 -> oValid stays 0, state IDLE, oBit_count=0.
6. Async reset pulse mid-frame after 7 bits -> all outputs 0 immediately. A full clean 16-bit frame afterwards decodes correctly with oValid=1.
